periph_tx_handshake: RTL and testbench
======================================

# periph_tx_handshake

Peripheral-to-CPU return path of the request/acknowledge link: buffers 2-bit words produced by the peripheral core and delivers them to the CPU-side receiver over a four-phase `req`/`ack` handshake. It is the initiator on the return direction, complementing the existing CPU-to-peripheral send/ack path. The block is single-clock; `ack` arrives from the far side through a configurable synchronizer.

## Interface
- `DATA_W`, 2, word width on both the core and link sides.
- `DEPTH`, 4, FIFO depth in words; must be a power of two, at least 2.
- `SYNC_STAGES`, 2, flops on `ack` before the FSM; 0 means direct use.
- `TIMEOUT`, 16, cycles spent in REQ without `ack` before `err` sets; at least 2.
- `clock`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_data`  in  DATA_W  word from the peripheral core.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO can accept; a push occurs at an edge where `in_valid` and `in_ready` are both 1.
- `req`  out  1  link request to the CPU side; registered.
- `tx_data`  out  DATA_W  link data; registered; stable whenever `req` is 1.
- `ack`  in  1  link acknowledge from the CPU side.
- `busy`  out  1  high when the state is not IDLE or the FIFO is not empty.
- `level`  out  clog2(DEPTH)+1  current FIFO occupancy.
- `err`  out  1  sticky timeout flag.

## Operation
- Reset, when `reset` is 1 at an edge:
  - `req`=0, `tx_data`=0, `err`=0, FSM=IDLE.
  - FIFO is flushed (`level`=0) and all synchronizer flops are cleared.
  - Pushes are ignored while `reset` is 1, and `in_ready` is forced to 0.
- FIFO:
  - Circular buffer with wrapping read and write pointers and an occupancy counter.
  - `in_ready` = (`level` < DEPTH) and not `reset`.
  - When a push and a pop occur in the same cycle, `level` is unchanged.
  - The FIFO never overwrites data when full and never pops when empty.
- `ack_s` is `ack` delayed through SYNC_STAGES flops.
- FSM states:
  - IDLE: if `level` != 0, load `tx_data` from the FIFO head, set `req`=1 and go to REQ. Otherwise hold `req`=0 and `tx_data`=0.
  - REQ: `req`=1 and `tx_data` is held.
    - If `ack_s`=1: pop the FIFO, set `req`=0 and `tx_data`=0, clear the timeout counter, go to REL.
    - Otherwise increment the timeout counter, saturating. When the counter reaches TIMEOUT, set `err`=1. `req` stays high and the transfer is not abandoned.
  - REL: `req`=0.
    - If `ack_s`=0 and the FIFO is not empty, load the new head, set `req`=1 and go to REQ.
    - If `ack_s`=0 and the FIFO is empty, go to IDLE.
    - If `ack_s`=1, stay in REL.
- `err` clears only on reset.
- The FIFO head is popped only in the REQ→REL transition. A word pushed in the same cycle as a pop is never lost.

## Timing
- The word pushed at edge k is already visible at the FIFO head. If the FSM is in IDLE, `req` rises after edge k+1.
- `ack` that is first sampled high at edge e becomes `ack_s`=1 after edge e+SYNC_STAGES-1. The FSM reacts at edge e+SYNC_STAGES, where `req` falls and the FIFO pops.
- The `ack` fall follows the same delay: the REL exit happens at edge (fall sample)+SYNC_STAGES.
- Throughput with SYNC_STAGES=2 and a zero-latency responder: one word per 6 cycles.
  - 1 cycle for `req` to reach the responder.
  - 2+1 cycles for the `ack` rise to be seen.
  - 2 cycles for the `ack` fall to be seen.
- Reset in mid-handshake:
  - `req` is 0 after the reset edge and the in-flight word is discarded.
  - The far side must see `req` low and return `ack` low. The FSM waits in IDLE and ignores a stale `ack` because it only acts on the FIFO level.

## Test plan
- Reset, then push `in_data`=2'b10 at edge 1 with a responder that raises `ack` one cycle after `req` and drops it one cycle after `req` falls.
  - `req`=1 after edge 2 with `tx_data`=2'b10.
  - `req`=0 and `tx_data`=0 after edge 5.
  - `level` returns to 0, and `busy`=0 after REL exits.
- Push 4 words (01,10,11,00) back-to-back while `ack` is held low.
  - `level`=4 and `in_ready`=0.
  - A fifth push is ignored.
  - After the `ack` responder is released, words appear on `tx_data` in order 01,10,11,00 with `req` toggling for each.
- Hold `ack`=0 for 20 cycles after `req` rises.
  - `err`=1 after TIMEOUT cycles in REQ.
  - `req` and `tx_data` remain stable.
  - A later `ack` completes the transfer, and `err` stays 1.
- With FIFO `level`=3 and the FSM in REQ, push a word on the same edge that `ack_s` causes a pop.
  - `level` stays 3.
  - The next word sent is the next in order.
- Assert `reset` for one cycle while in REQ with `level`=2.
  - After the edge, `req`=0, `tx_data`=0, `level`=0, `err`=0 and the FSM is in IDLE.
  - A new push produces `req` two edges later.
- Set SYNC_STAGES=0 and repeat the first scenario.
  - `req` falls at the edge where `ack` is first sampled high.

Source files
------------

// File: rtl/periph_tx_handshake_if.sv
// periph_tx_handshake_if
// Bundles the core-side push port and the link-side four-phase port of the
// peripheral-to-CPU return path.
//   in_data / in_valid / in_ready : word push from the peripheral core
//   req / tx_data / ack           : request/acknowledge link towards the CPU side
// Modports:
//   master : the return-path block (link initiator, FIFO owner)
//   slave  : its environment (core producer plus CPU-side responder)
interface periph_tx_handshake_if #(
    parameter int DATA_W = 2
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              req;
    logic [DATA_W-1:0] tx_data;
    logic              ack;

    modport master (
        input  in_data, in_valid, ack,
        output in_ready, req, tx_data
    );

    modport slave (
        output in_data, in_valid, ack,
        input  in_ready, req, tx_data
    );
endinterface

// File: rtl/periph_tx_handshake.sv
// periph_tx_handshake
// Buffers words from the peripheral core in a small FIFO and delivers them to
// the CPU side over a four-phase req/ack handshake. ack is brought in through
// a SYNC_STAGES-deep flop chain (0 = used directly). A REQ phase that waits
// TIMEOUT cycles without ack raises a sticky err; the transfer still completes.
// Ports:
//   clock  : single clock, rising edge
//   reset  : synchronous, active-high
//   link   : periph_tx_handshake_if.master (in_data/in_valid/in_ready, req/tx_data/ack)
//   busy   : FSM not idle or FIFO not empty
//   level  : FIFO occupancy
//   err    : sticky handshake timeout flag
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no transfer; req low, waiting for the FIFO to hold a word
// ST_REQ  | req high with the FIFO head on tx_data, waiting for ack_s rise
// ST_REL  | word popped, req low, waiting for ack_s to fall
module periph_tx_handshake #(
    parameter int DATA_W      = 2,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    periph_tx_handshake_if.master  link,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    state_t            state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     count;
    logic              push, pop;
    logic              fifo_ne;
    logic [DATA_W-1:0] head;

    logic              ack_s;

    logic              req_nxt;
    logic [DATA_W-1:0] tx_nxt;
    logic [TW-1:0]     tmr, tmr_nxt;
    logic              err_set;

    // ---------------- FIFO ----------------
    assign link.in_ready = (count < FULL_LVL) && !reset;
    assign push          = link.in_valid && link.in_ready;
    assign fifo_ne       = (count != '0);
    assign head          = mem[rd_ptr];
    assign level         = count;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= link.in_data;
        end
    end

    // pop only happens in ST_REQ, where the word being sent is still counted,
    // so the FIFO can never underflow
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // ---------------- ack synchronizer ----------------
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign ack_s = link.ack;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clock) begin
                if (reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= link.ack;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end
            assign ack_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // ---------------- FSM ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (fifo_ne) state_nxt = ST_REQ;
            ST_REQ:  if (ack_s)   state_nxt = ST_REL;
            ST_REL:  if (!ack_s)  state_nxt = fifo_ne ? ST_REQ : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The timeout timer counts down from TIMEOUT on every entry into ST_REQ;
    // err is raised on the cycle it reaches zero, then it holds at zero.
    always_comb begin
        req_nxt = link.req;
        tx_nxt  = link.tx_data;
        tmr_nxt = tmr;
        err_set = 1'b0;
        pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fifo_ne) begin
                    req_nxt = 1'b1;
                    tx_nxt  = head;
                    tmr_nxt = TMR_LOAD;
                end else begin
                    req_nxt = 1'b0;
                    tx_nxt  = '0;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    pop     = 1'b1;
                    req_nxt = 1'b0;
                    tx_nxt  = '0;
                    tmr_nxt = TMR_LOAD;
                end else if (tmr != '0) begin
                    tmr_nxt = tmr - 1'b1;
                    err_set = (tmr == TW'(1));
                end
            end
            ST_REL: begin
                req_nxt = 1'b0;
                if (!ack_s && fifo_ne) begin
                    req_nxt = 1'b1;
                    tx_nxt  = head;
                    tmr_nxt = TMR_LOAD;
                end
            end
            default: begin
                req_nxt = 1'b0;
                tx_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            link.req     <= 1'b0;
            link.tx_data <= '0;
            tmr          <= TMR_LOAD;
            err          <= 1'b0;
        end else begin
            link.req     <= req_nxt;
            link.tx_data <= tx_nxt;
            tmr          <= tmr_nxt;
            if (err_set) err <= 1'b1;
        end
    end

    assign busy = (state != ST_IDLE) || fifo_ne;
endmodule

// File: tb/tb_periph_tx_handshake.sv
// tb_periph_tx_handshake
// Directed scenarios plus a randomized run of periph_tx_handshake against a
// transaction-level reference model (word queue, handshake phase, ack history).
// A second instance with SYNC_STAGES=0 covers the direct-ack timing.
module tb_periph_tx_handshake;
    localparam int DW    = 2;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int TMO   = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset, reset0;
    logic       busy, err, busy0, err0;
    logic [2:0] level, level0;

    periph_tx_handshake_if #(.DATA_W(DW)) bus ();
    periph_tx_handshake_if #(.DATA_W(DW)) bus0 ();

    periph_tx_handshake #(.DATA_W(DW), .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .link(bus.master),
        .busy(busy), .level(level), .err(err));

    periph_tx_handshake #(.DATA_W(DW), .DEPTH(DEPTH), .SYNC_STAGES(0), .TIMEOUT(TMO)) dut0 (
        .clock(clock), .reset(reset0), .link(bus0.master),
        .busy(busy0), .level(level0), .err(err0));

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mmode: 0 idle, 1 request outstanding, 2 waiting for ack release
    int mq[$];
    int mmode;
    bit mreq;
    int mtx;
    bit merr;
    int mwait;
    bit mhist[$];

    task automatic model_reset();
        mq.delete();
        mhist.delete();
        for (int i = 0; i < SYNC; i++) mhist.push_back(1'b0);
        mmode = 0;
        mreq  = 1'b0;
        mtx   = 0;
        merr  = 1'b0;
        mwait = 0;
    endtask

    task automatic model_step(input bit r, input bit v, input int d, input bit a);
        bit as_s;
        int lvl;
        if (r) begin
            model_reset();
            return;
        end
        lvl = mq.size();
        if (SYNC == 0) begin
            as_s = a;
        end else begin
            as_s = mhist[0];
            mhist.push_back(a);
            void'(mhist.pop_front());
        end
        case (mmode)
            0: begin
                if (lvl != 0) begin
                    mreq = 1'b1; mtx = mq[0]; mmode = 1; mwait = 0;
                end else begin
                    mreq = 1'b0; mtx = 0;
                end
            end
            1: begin
                if (as_s) begin
                    void'(mq.pop_front());
                    mreq = 1'b0; mtx = 0; mwait = 0; mmode = 2;
                end else begin
                    if (mwait < TMO) mwait++;
                    if (mwait == TMO) merr = 1'b1;
                end
            end
            default: begin
                if (!as_s) begin
                    if (lvl != 0) begin
                        mreq = 1'b1; mtx = mq[0]; mmode = 1; mwait = 0;
                    end else begin
                        mmode = 0;
                    end
                end
            end
        endcase
        if (v && lvl < DEPTH) mq.push_back(d);
    endtask

    task automatic compare_all();
        check_val("req", bus.req, mreq);
        check_val("tx_data", bus.tx_data, mtx);
        check_val("level", level, mq.size());
        check_val("in_ready", bus.in_ready, (mq.size() < DEPTH) && !reset);
        check_val("busy", busy, (mmode != 0) || (mq.size() != 0));
        check_val("err", err, merr);
    endtask

    // ---------------- clocking helpers ----------------
    // resp_mode: 0 manual ack, 1 zero-latency responder, 2 random-latency responder
    int   resp_mode;
    logic prev_req;
    int   obs[$];

    task automatic tick();
        @(posedge clock);
        model_step(reset, bus.in_valid, int'(bus.in_data), bus.ack);
        #1;
        compare_all();
        if (bus.req && !prev_req) obs.push_back(int'(bus.tx_data));
        prev_req = bus.req;
        if (resp_mode == 1) begin
            bus.ack = bus.req;
        end else if (resp_mode == 2 && bus.ack != bus.req && $urandom_range(0, 2) == 0) begin
            bus.ack = bus.req;
        end
    endtask

    task automatic push_word(input int d);
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(d);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check_val(tag, n < 100, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    int seq4 [4] = '{1, 2, 3, 0};
    int seq5 [4] = '{3, 1, 2, 0};

    initial begin
        reset = 1'b1; reset0 = 1'b1; resp_mode = 0; prev_req = 1'b0;
        bus.in_valid  = 1'b0; bus.in_data  = '0; bus.ack  = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.ack = 1'b0;
        model_reset();
        #2;
        tick();
        tick();
        check_val("rst_req", bus.req, 0);
        check_val("rst_level", level, 0);
        check_val("rst_in_ready", bus.in_ready, 0);
        check_val("rst_err", err, 0);
        reset = 1'b0;

        // single word with zero-latency responder
        resp_mode = 1;
        push_word(2);                      // edge 1
        tick();                            // edge 2
        check_val("s1_req_rise", bus.req, 1);
        check_val("s1_tx", bus.tx_data, 2);
        tick(); tick(); tick();            // edges 3..5
        check_val("s1_req_fall", bus.req, 0);
        check_val("s1_tx_zero", bus.tx_data, 0);
        check_val("s1_level", level, 0);
        tick(); tick();                    // edges 6,7
        check_val("s1_busy_rel", busy, 1);
        tick();                            // edge 8
        check_val("s1_busy_done", busy, 0);

        // fill the FIFO while ack is held low
        resp_mode = 0; bus.ack = 1'b0;
        obs.delete();
        for (int i = 0; i < 4; i++) push_word(seq4[i]);
        check_val("s2_level_full", level, 4);
        check_val("s2_in_ready", bus.in_ready, 0);
        push_word(1);
        check_val("s2_fifth_ignored", level, 4);
        resp_mode = 1; bus.ack = bus.req;
        drain("s2_drain");
        check_val("s2_count", obs.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < obs.size()) check_val("s2_order", obs[i], seq4[i]);

        // simultaneous push and pop at level 3
        resp_mode = 0; bus.ack = 1'b0;
        obs.delete();
        for (int i = 0; i < 3; i++) push_word(seq5[i]);
        check_val("s4_level3", level, 3);
        check_val("s4_in_req", bus.req, 1);
        bus.ack = 1'b1;
        tick(); tick();
        check_val("s4_req_hold", bus.req, 1);
        push_word(seq5[3]);
        check_val("s4_req_fall", bus.req, 0);
        check_val("s4_level_kept", level, 3);
        resp_mode = 1; bus.ack = bus.req;
        drain("s4_drain");
        check_val("s4_count", obs.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < obs.size()) check_val("s4_order", obs[i], seq5[i]);

        // timeout while ack stays low
        resp_mode = 0; bus.ack = 1'b0;
        push_word(3);
        tick();
        check_val("t_req_rise", bus.req, 1);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == TMO - 1) check_val("t_err_early", err, 0);
            if (i == TMO) check_val("t_err_set", err, 1);
            check_val("t_req_hold", bus.req, 1);
            check_val("t_tx_hold", bus.tx_data, 3);
        end
        resp_mode = 1; bus.ack = bus.req;
        drain("t_drain");
        check_val("t_err_sticky", err, 1);
        check_val("t_level", level, 0);

        // reset in mid-handshake
        resp_mode = 0; bus.ack = 1'b0;
        push_word(1);
        push_word(2);
        check_val("r_level2", level, 2);
        check_val("r_in_req", bus.req, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("r_req", bus.req, 0);
        check_val("r_tx", bus.tx_data, 0);
        check_val("r_level", level, 0);
        check_val("r_err", err, 0);
        check_val("r_busy", busy, 0);
        push_word(2);
        check_val("r_req_wait", bus.req, 0);
        tick();
        check_val("r_req_new", bus.req, 1);
        resp_mode = 1; bus.ack = bus.req;
        drain("r_drain");

        // direct ack instance
        tick();
        reset0 = 1'b0;
        bus0.in_valid = 1'b1; bus0.in_data = 2'b10;
        tick();
        bus0.in_valid = 1'b0;
        tick();
        check_val("z_req_rise", bus0.req, 1);
        check_val("z_tx", bus0.tx_data, 2);
        bus0.ack = 1'b1;
        tick();
        check_val("z_req_fall", bus0.req, 0);
        check_val("z_tx_zero", bus0.tx_data, 0);
        check_val("z_level", level0, 0);
        check_val("z_busy_rel", busy0, 1);
        bus0.ack = 1'b0;
        tick();
        check_val("z_busy_done", busy0, 0);
        check_val("z_err", err0, 0);

        // randomized traffic
        resp_mode = 2;
        for (int c = 0; c < 2000; c++) begin
            bus.in_valid = ($urandom_range(0, 2) != 0);
            bus.in_data  = DW'($urandom_range(0, 3));
            reset        = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        bus.in_valid = 1'b0;
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
